// File: rtl/reorder_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | reorder_buffer : circular in-order commit queue with branch rollback |
// | Optional ROB_PERF_CNT_EN adds commit_cnt / mispredict_cnt outputs.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module reorder_buffer #(
   parameter int ROB_ID_W = 4,
   parameter int DATA_W   = 32,
   parameter int REG_W    = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                alloc_valid,
   input  logic [REG_W-1:0]    alloc_rd,
   input  logic                alloc_is_branch,
   input  logic                alloc_pred_taken,
   input  logic [31:0]         alloc_alt_pc,
   output logic [ROB_ID_W-1:0] alloc_tag,
   output logic                rob_full,
   input  logic [ROB_ID_W-1:0] qry1_tag,
   input  logic [ROB_ID_W-1:0] qry2_tag,
   output logic                qry1_ready,
   output logic                qry2_ready,
   output logic [DATA_W-1:0]   qry1_value,
   output logic [DATA_W-1:0]   qry2_value,
   input  logic                cdb_valid,
   input  logic [ROB_ID_W-1:0] cdb_tag,
   input  logic [DATA_W-1:0]   cdb_value,
   input  logic                cdb_taken,
   output logic                rob_has_res,
   output logic [DATA_W-1:0]   result_to_reg,
   output logic [REG_W-1:0]    regidx_to_reg,
   output logic [ROB_ID_W-1:0] regalias_to_reg,
   output logic                rollback_signal,
`ifdef ROB_PERF_CNT_EN
   output logic [31:0]         commit_cnt,
   output logic [31:0]         mispredict_cnt,
`endif
   output logic [31:0]         rollback_pc
);

   localparam int                  c_nent  = 1 << ROB_ID_W;
   localparam logic [ROB_ID_W-1:0] c_last  = '1;
   localparam logic [ROB_ID_W-1:0] c_one   = ROB_ID_W'(1);

   logic [ROB_ID_W-1:0] r_head;
   logic [ROB_ID_W-1:0] r_tail;
   logic [ROB_ID_W-1:0] r_count;
   logic [c_nent-1:0]   r_busy;
   logic [c_nent-1:0]   r_ready;
   logic [c_nent-1:0]   r_taken;
   logic [c_nent-1:0]   r_is_branch;
   logic [c_nent-1:0]   r_pred_taken;
   logic [DATA_W-1:0]   r_value  [c_nent];
   logic [REG_W-1:0]    r_rd     [c_nent];
   logic [31:0]         r_alt_pc [c_nent];

   logic w_active;
   logic w_do_alloc;
   logic w_do_wb;
   logic w_do_commit;
   logic w_mispredict;
   logic w_writes_reg;

   // Tag 0 is reserved for "no alias", so pointers wrap from the last tag to 1.
   function automatic logic [ROB_ID_W-1:0] next_ptr(input logic [ROB_ID_W-1:0] p);
      return (p == c_last) ? c_one : p + c_one;
   endfunction

   assign alloc_tag = r_tail;
   assign rob_full  = (r_count == c_last);

   // The cycle that presents rollback_signal is the flush cycle: nothing else may act.
   assign w_active     = rdy && !rollback_signal;
   assign w_do_alloc   = w_active && alloc_valid && !rob_full;
   assign w_do_wb      = w_active && cdb_valid && (cdb_tag != '0) && r_busy[cdb_tag];
   assign w_do_commit  = w_active && r_busy[r_head] && r_ready[r_head];
   assign w_mispredict = w_do_commit && r_is_branch[r_head]
                         && (r_taken[r_head] != r_pred_taken[r_head]);
   assign w_writes_reg = w_do_commit && !r_is_branch[r_head] && (r_rd[r_head] != '0);

   always_comb begin
      qry1_ready = 1'b0;
      qry1_value = '0;
      qry2_ready = 1'b0;
      qry2_value = '0;
      if (qry1_tag != '0) begin
         if (r_busy[qry1_tag] && r_ready[qry1_tag]) begin
            qry1_ready = 1'b1;
            qry1_value = r_value[qry1_tag];
         end else if (cdb_valid && cdb_tag == qry1_tag) begin
            qry1_ready = 1'b1;
            qry1_value = cdb_value;
         end
      end
      if (qry2_tag != '0) begin
         if (r_busy[qry2_tag] && r_ready[qry2_tag]) begin
            qry2_ready = 1'b1;
            qry2_value = r_value[qry2_tag];
         end else if (cdb_valid && cdb_tag == qry2_tag) begin
            qry2_ready = 1'b1;
            qry2_value = cdb_value;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head          <= c_one;
         r_tail          <= c_one;
         r_count         <= '0;
         r_busy          <= '0;
         r_ready         <= '0;
         rob_has_res     <= 1'b0;
         rollback_signal <= 1'b0;
         result_to_reg   <= '0;
         regidx_to_reg   <= '0;
         regalias_to_reg <= '0;
         rollback_pc     <= '0;
      end else if (rollback_signal) begin
         r_head          <= c_one;
         r_tail          <= c_one;
         r_count         <= '0;
         r_busy          <= '0;
         r_ready         <= '0;
         rob_has_res     <= 1'b0;
         rollback_signal <= 1'b0;
      end else begin
         rob_has_res     <= w_writes_reg;
         rollback_signal <= w_mispredict;
         if (w_writes_reg) begin
            result_to_reg   <= r_value[r_head];
            regidx_to_reg   <= r_rd[r_head];
            regalias_to_reg <= r_head;
         end
         if (w_mispredict) begin
            rollback_pc <= r_alt_pc[r_head];
         end
         if (w_do_wb) begin
            r_ready[cdb_tag] <= 1'b1;
         end
         if (w_do_commit) begin
            r_busy[r_head]  <= 1'b0;
            r_ready[r_head] <= 1'b0;
            r_head          <= next_ptr(r_head);
         end
         if (w_do_alloc) begin
            r_busy[r_tail]  <= 1'b1;
            r_ready[r_tail] <= 1'b0;
            r_tail          <= next_ptr(r_tail);
         end
         case ({w_do_alloc, w_do_commit})
            2'b10:   r_count <= r_count + c_one;
            2'b01:   r_count <= r_count - c_one;
            default: r_count <= r_count;
         endcase
      end
   end

   // Payload storage needs no reset: busy/ready qualify every read.
   always_ff @(posedge clk) begin
      if (w_do_wb) begin
         r_value[cdb_tag] <= cdb_value;
         r_taken[cdb_tag] <= cdb_taken;
      end
      if (w_do_alloc) begin
         r_rd[r_tail]         <= alloc_rd;
         r_is_branch[r_tail]  <= alloc_is_branch;
         r_pred_taken[r_tail] <= alloc_pred_taken;
         r_alt_pc[r_tail]     <= alloc_alt_pc;
      end
   end

`ifdef ROB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         commit_cnt     <= '0;
         mispredict_cnt <= '0;
      end else begin
         if (w_do_commit) begin
            commit_cnt <= commit_cnt + 32'd1;
         end
         if (w_mispredict) begin
            mispredict_cnt <= mispredict_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_reorder_buffer : randomized scoreboard bench for reorder_buffer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_reorder_buffer;

   localparam int NMAX = 15;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rdy, alloc_valid, alloc_is_branch, alloc_pred_taken;
   logic [4:0]  alloc_rd;
   logic [31:0] alloc_alt_pc;
   logic [3:0]  alloc_tag, qry1_tag, qry2_tag, cdb_tag, regalias_to_reg;
   logic        rob_full, qry1_ready, qry2_ready, cdb_valid, cdb_taken;
   logic [31:0] qry1_value, qry2_value, cdb_value, result_to_reg, rollback_pc;
   logic        rob_has_res, rollback_signal;
   logic [4:0]  regidx_to_reg;

   reorder_buffer dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_branch(alloc_is_branch),
      .alloc_pred_taken(alloc_pred_taken), .alloc_alt_pc(alloc_alt_pc),
      .alloc_tag(alloc_tag), .rob_full(rob_full),
      .qry1_tag(qry1_tag), .qry2_tag(qry2_tag),
      .qry1_ready(qry1_ready), .qry2_ready(qry2_ready),
      .qry1_value(qry1_value), .qry2_value(qry2_value),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value), .cdb_taken(cdb_taken),
      .rob_has_res(rob_has_res), .result_to_reg(result_to_reg),
      .regidx_to_reg(regidx_to_reg), .regalias_to_reg(regalias_to_reg),
      .rollback_signal(rollback_signal), .rollback_pc(rollback_pc)
   );

   // staged stimulus, applied at the next falling edge by step()
   logic        s_rst, s_rdy, s_av, s_br, s_pt, s_cv, s_tk;
   logic [4:0]  s_rd;
   logic [31:0] s_pc, s_cval;
   logic [3:0]  s_ct, s_q1, s_q2;

   typedef struct {
      int tag; int rd; bit br; bit pt; bit done; bit tk;
      logic [31:0] pc; logic [31:0] val;
   } ent_t;
   typedef struct {
      int cyc; bit rb; logic [31:0] val; int rd; int tag; logic [31:0] pc;
   } ev_t;

   ent_t mq[$];      // in-flight entries, oldest first
   ev_t  exp_q[$];   // expected commit/rollback pulses
   int   ntag  = 1;
   bit   flush = 0;
   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   ev_t  mon_ev;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
      n_cmp++;
      if (act !== ex) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, ex, cyc);
      end
   endtask

   function automatic void qmodel(input int t, output bit r, output logic [31:0] v);
      r = 0;
      v = '0;
      if (t == 0) return;
      foreach (mq[i]) begin
         if (mq[i].tag == t && mq[i].done) begin
            r = 1;
            v = mq[i].val;
            return;
         end
      end
      if (s_cv && s_ct == t) begin
         r = 1;
         v = s_cval;
      end
   endfunction

   task automatic idle();
      s_rst = 0; s_rdy = 1; s_av = 0; s_br = 0; s_pt = 0; s_cv = 0; s_tk = 0;
      s_rd = 0; s_pc = 0; s_cval = 0; s_ct = 0; s_q1 = 0; s_q2 = 0;
   endtask

   task automatic step();
      bit          r, full;
      logic [31:0] v;
      ent_t        e;
      ev_t         x;
      @(negedge clk);
      rst = s_rst; rdy = s_rdy; alloc_valid = s_av; alloc_rd = s_rd;
      alloc_is_branch = s_br; alloc_pred_taken = s_pt; alloc_alt_pc = s_pc;
      cdb_valid = s_cv; cdb_tag = s_ct; cdb_value = s_cval; cdb_taken = s_tk;
      qry1_tag = s_q1; qry2_tag = s_q2;
      #1;
      if (!s_rst) begin
         chk("alloc_tag", alloc_tag, ntag);
         chk("rob_full", rob_full, mq.size() == NMAX);
         qmodel(s_q1, r, v);
         chk("qry1_ready", qry1_ready, r);
         if (r) chk("qry1_value", qry1_value, v);
         qmodel(s_q2, r, v);
         chk("qry2_ready", qry2_ready, r);
         if (r) chk("qry2_value", qry2_value, v);
      end
      // reference model for the coming rising edge
      if (s_rst || flush) begin
         mq.delete();
         ntag  = 1;
         flush = 0;
      end else if (s_rdy) begin
         full = (mq.size() == NMAX);
         if (mq.size() > 0 && mq[0].done) begin
            e = mq.pop_front();
            x.cyc = cyc + 1; x.val = e.val; x.rd = e.rd; x.tag = e.tag; x.pc = e.pc;
            if (e.br && e.tk != e.pt) begin
               x.rb = 1;
               exp_q.push_back(x);
               flush = 1;
            end else if (!e.br && e.rd != 0) begin
               x.rb = 0;
               exp_q.push_back(x);
            end
         end
         if (s_cv && s_ct != 0) begin
            foreach (mq[i]) begin
               if (mq[i].tag == s_ct) begin
                  mq[i].done = 1; mq[i].val = s_cval; mq[i].tk = s_tk;
               end
            end
         end
         if (s_av && !full) begin
            e.tag = ntag; e.rd = s_rd; e.br = s_br; e.pt = s_pt; e.pc = s_pc;
            e.done = 0; e.tk = 0; e.val = 0;
            mq.push_back(e);
            ntag = (ntag == NMAX) ? 1 : ntag + 1;
         end
      end
   endtask

   task automatic do_alloc(input int rd, input bit br, input bit pt, input logic [31:0] pc);
      idle();
      s_av = 1; s_rd = 5'(rd); s_br = br; s_pt = pt; s_pc = pc;
      step();
      idle();
   endtask

   task automatic do_wb(input int tag, input logic [31:0] val, input bit tk);
      idle();
      s_cv = 1; s_ct = 4'(tag); s_cval = val; s_tk = tk; s_q1 = 4'(tag);
      step();
      idle();
   endtask

   task automatic do_reset();
      idle();
      s_rst = 1;
      step();
      idle();
   endtask

   // Monitor: every pulse the DUT shows must match the head of the expected queue.
   always begin
      @(posedge clk);
      cyc++;
      #1;
      if (rob_has_res !== 1'b0 || rollback_signal !== 1'b0) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: rob_has_res=%b rollback_signal=%b, expected none (cycle %0d)",
                     rob_has_res, rollback_signal, cyc);
         end else begin
            mon_ev = exp_q.pop_front();
            chk("pulse_cycle", cyc, mon_ev.cyc);
            chk("rollback_signal", rollback_signal, mon_ev.rb);
            chk("rob_has_res", rob_has_res, !mon_ev.rb);
            if (mon_ev.rb) begin
               chk("rollback_pc", rollback_pc, mon_ev.pc);
            end else begin
               chk("result_to_reg", result_to_reg, mon_ev.val);
               chk("regidx_to_reg", regidx_to_reg, mon_ev.rd);
               chk("regalias_to_reg", regalias_to_reg, mon_ev.tag);
            end
         end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL missing_pulse: got no pulse, expected %s at cycle %0d",
                  exp_q[0].rb ? "rollback" : "commit", exp_q[0].cyc);
         void'(exp_q.pop_front());
      end
   end

   initial begin
      int pa, pw;
      idle();
      s_rst = 1;
      rst = 1; rdy = 1; alloc_valid = 0; alloc_rd = 0; alloc_is_branch = 0;
      alloc_pred_taken = 0; alloc_alt_pc = 0; cdb_valid = 0; cdb_tag = 0;
      cdb_value = 0; cdb_taken = 0; qry1_tag = 0; qry2_tag = 0;
      step();
      step();
      idle();
      chk("reset_alloc_tag", alloc_tag, 1);
      chk("reset_rob_full", rob_full, 0);
      chk("reset_rob_has_res", rob_has_res, 0);
      chk("reset_rollback_signal", rollback_signal, 0);
      chk("reset_result_to_reg", result_to_reg, 0);
      chk("reset_regidx_to_reg", regidx_to_reg, 0);
      chk("reset_regalias_to_reg", regalias_to_reg, 0);
      chk("reset_rollback_pc", rollback_pc, 0);

      // single alloc / writeback / commit
      do_alloc(5, 0, 0, 0);
      do_wb(1, 32'h1234, 0);
      repeat (3) step();

      // fill to full, ignored 16th alloc, tail wraps to 1 once head frees
      do_reset();
      for (int i = 0; i < 15; i++) do_alloc(i % 8, 0, 0, 0);
      do_alloc(9, 0, 0, 0);
      do_wb(1, 32'hAAAA, 0);
      repeat (2) step();
      do_alloc(3, 0, 0, 0);
      step();

      // out-of-order writeback, in-order commit
      do_reset();
      do_alloc(1, 0, 0, 0);
      do_alloc(2, 0, 0, 0);
      do_wb(2, 32'h22, 0);
      do_wb(1, 32'h11, 0);
      repeat (3) step();

      // mispredicted branch with ready younger entries
      do_reset();
      do_alloc(0, 1, 0, 32'h100);
      do_alloc(6, 0, 0, 0);
      do_alloc(7, 0, 0, 0);
      do_wb(2, 32'h66, 0);
      do_wb(3, 32'h77, 0);
      do_wb(1, 32'h0, 1);
      repeat (4) step();

      // same-cycle bypass on query port 1
      do_alloc(4, 0, 0, 0);
      do_alloc(4, 0, 0, 0);
      do_alloc(4, 0, 0, 0);
      do_wb(3, 32'h55, 0);
      repeat (4) step();

      // rdy low for three cycles with a ready head
      do_reset();
      do_alloc(7, 0, 0, 0);
      do_wb(1, 32'hBEEF, 0);
      s_rdy = 0;
      repeat (3) step();
      idle();
      repeat (2) step();

      // randomized phases with varying alloc/writeback pressure
      for (int p = 0; p < 4; p++) begin
         pa = (p == 1) ? 90 : 55;
         pw = (p == 1) ? 15 : (p == 2) ? 80 : 50;
         for (int n = 0; n < 800; n++) begin
            idle();
            s_rst = ($urandom_range(0, 499) == 0);
            s_rdy = ($urandom_range(0, 9) != 0);
            s_av  = ($urandom_range(0, 99) < pa);
            s_rd  = 5'($urandom);
            s_br  = ($urandom_range(0, 3) == 0);
            s_pt  = 1'($urandom);
            s_pc  = $urandom;
            s_cv  = ($urandom_range(0, 99) < pw);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
               s_ct = 4'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
               s_ct = 4'($urandom);
            s_cval = $urandom;
            s_tk   = ($urandom_range(0, 3) == 0) ? !s_pt : s_pt;
            s_q1   = ($urandom_range(0, 3) == 0) ? s_ct : 4'($urandom);
            s_q2   = (mq.size() > 0) ? 4'(mq[$urandom_range(0, mq.size() - 1)].tag) : 4'($urandom);
            step();
         end
      end

      idle();
      repeat (40) begin
         if (mq.size() > 0 && !mq[0].done) begin
            s_cv = 1; s_ct = 4'(mq[0].tag); s_cval = $urandom; s_tk = 1'($urandom);
         end
         step();
         idle();
      end
      @(posedge clk);
      #3;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameters: ROB_ID_W, default 4, tag width; DATA_W, default 32, value width; REG_W, default 5, architectural register index width.
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes state
- alloc_valid  in  1  dispatcher allocates one entry
- alloc_rd  in  REG_W  destination register (0 = none)
- alloc_is_branch  in  1  entry is a conditional branch
- alloc_pred_taken  in  1  predicted direction
- alloc_alt_pc  in  32  PC to restart at if mispredicted
- alloc_tag  out  ROB_ID_W  tag the next allocation receives (combinational)
- rob_full  out  1  no free entry (combinational from registered count)
- qry1_tag, qry2_tag  in  ROB_ID_W  operand tags from dispatcher
- qry1_ready, qry2_ready  out  1  queried entry has a value
- qry1_value, qry2_value  out  DATA_W  queried entry value
- cdb_valid  in  1  writeback strobe
- cdb_tag  in  ROB_ID_W  writeback tag
- cdb_value  in  DATA_W  writeback value
- cdb_taken  in  1  resolved branch direction
- rob_has_res  out  1  commit write to register file, one-cycle pulse
- result_to_reg  out  DATA_W  committed value
- regidx_to_reg  out  REG_W  committed destination
- regalias_to_reg  out  ROB_ID_W  committed tag
- rollback_signal  out  1  mispredict flush, one-cycle pulse
- rollback_pc  out  32  restart PC
REQ-003 SHALL use only tags 1..2^ROB_ID_W-1 (15 entries by default); tag 0 means "no alias".

Function
REQ-004 SHALL keep a circular queue of registered pointers head (oldest entry), tail (next free entry), and count (0..15); alloc_tag = tail; rob_full = (count == 15).
REQ-005 Pointers SHALL advance 1,2,...,15,1; the successor of 15 is 1, never 0.
REQ-006 On posedge with rdy=1, no rollback pending, alloc_valid=1 and rob_full=0, the entry at tail SHALL be set busy, not ready, and filled with the alloc fields; tail SHALL advance.
REQ-007 alloc_valid while rob_full=1 SHALL be ignored, even when a commit happens in the same cycle.
REQ-008 On posedge with cdb_valid=1 and the entry at cdb_tag busy, that entry SHALL record value and taken and become ready; a writeback to a non-busy tag or to tag 0 SHALL be ignored.
REQ-009 qryN_ready SHALL be 1 when the entry at qryN_tag is busy and ready (value = stored value), or when cdb_valid=1 and cdb_tag==qryN_tag (value = cdb_value, same-cycle bypass); it SHALL be 0 otherwise and for tag 0.
REQ-010 At most one entry SHALL commit per cycle: the head entry, when it is busy and was ready at the clock edge; earliest commit is the posedge after its writeback edge.
REQ-011 Commit of a non-branch with rd != 0 SHALL register rob_has_res=1, result_to_reg=value, regidx_to_reg=rd, and regalias_to_reg=head tag for exactly one cycle.
REQ-012 Commit with rd=0, or of a correctly predicted branch, SHALL free the entry with rob_has_res=0.
REQ-013 Commit of a branch whose taken != pred_taken SHALL register rollback_signal=1 and rollback_pc=alt_pc for one cycle.
REQ-014 On the edge after rollback_signal=1, all entries SHALL be cleared and set to head=tail=1, count=0; alloc, writeback, and commit SHALL be ignored on that edge.
REQ-015 Alloc and commit on the same edge SHALL leave count unchanged; head and tail SHALL both advance.
REQ-016 With rdy=0, all queue state SHALL hold and rob_has_res and rollback_signal SHALL be driven 0 on that edge.
REQ-017 count SHALL be updated by +1 on alloc, -1 on commit, and reset to 0 on rollback; it SHALL never leave 0..15.

Reset
REQ-018 On posedge with rst=1 (priority over rdy): head=tail=1, count=0, all entries not busy, rob_has_res=0, rollback_signal=0, result_to_reg=0, regidx_to_reg=0, regalias_to_reg=0, rollback_pc=0.
REQ-019 Reset mid-operation SHALL discard all in-flight entries; no commit pulse SHALL appear on or after the reset edge until a new entry completes.

Configuration
REQ-020 With macro ROB_PERF_CNT_EN defined, SHALL add outputs commit_cnt (32) and mispredict_cnt (32), reset to 0, each incrementing on every committed entry and every rollback respectively and wrapping modulo 2^32.
REQ-021 Without ROB_PERF_CNT_EN, those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-022 Reset, then alloc rd=5, writeback tag 1 value 0x1234 -> alloc_tag 1 then 2; the edge after writeback gives rob_has_res=1, regidx=5, alias=1, result=0x1234 for one cycle.
REQ-023 Allocate 15 entries without writeback -> rob_full=1, a 16th alloc is ignored, and tag after 15 wraps to 1 after head frees.
REQ-024 Out-of-order writeback of tags 2 then 1 -> commits in order 1, 2 on consecutive cycles.
REQ-025 Branch pred_taken=0 with alt_pc=0x100, writeback taken=1, younger entries present -> rollback_signal=1 with rollback_pc=0x100, the younger entries produce no commit, then count=0 and alloc_tag=1.
REQ-026 Query tag 3 while cdb_valid=1 with cdb_tag=3 and value 0x55 -> qry1_ready=1 and qry1_value=0x55 the same cycle.
REQ-027 Hold rdy=0 for 3 cycles with a ready head -> no commit and pointers stable; the commit appears on the first edge with rdy=1.
